// File: rtl/spec_rob_pkg.sv
// Shared field widths, entry layout and packed entry type for the speculative
// rename/reorder buffer.
package spec_rob_pkg;

  localparam int unsigned ROB_DEPTH  = 32;
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_PC_W   = 32;
  localparam int unsigned ROB_RD_W   = 5;
  localparam int unsigned ROB_TYPE_W = 2;
  localparam int unsigned ROB_NRD    = 2;

  // Entry bit offsets, LSB first: {rd, pc, type, spec_data, spec_valid, valid}
  localparam int unsigned VALID_LSB      = 0;
  localparam int unsigned SPEC_VALID_LSB = 1;
  localparam int unsigned DATA_LSB       = 2;
  localparam int unsigned TYPE_LSB       = DATA_LSB + ROB_DATA_W;
  localparam int unsigned PC_LSB         = TYPE_LSB + ROB_TYPE_W;
  localparam int unsigned RD_LSB         = PC_LSB + ROB_PC_W;
  localparam int unsigned ENTRY_W        = RD_LSB + ROB_RD_W;

  typedef struct packed {
    logic [ROB_RD_W-1:0]   rd;
    logic [ROB_PC_W-1:0]   pc;
    logic [ROB_TYPE_W-1:0] itype;
    logic [ROB_DATA_W-1:0] spec_data;
    logic                  spec_valid;
    logic                  valid;
  } rob_entry_t;

endpackage

// File: rtl/spec_rob_ptr.sv
// Head/tail/count bookkeeping for the reorder buffer; flush and the full
// check on pre-edge occupancy live here.
module spec_rob_ptr #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          alloc_req_i,
  input  logic          retire_req_i,
  output logic          alloc_fire_o,
  output logic          retire_fire_o,
  output logic [AW-1:0] head_o,
  output logic [AW-1:0] tail_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    full_o        = (count_q == FULL_CNT);
    empty_o       = (count_q == '0);
    alloc_fire_o  = alloc_req_i & ~full_o & ~flush_i;
    retire_fire_o = retire_req_i & ~flush_i;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow gives the modulo wrap.
      if (alloc_fire_o)  tail_d = tail_q + AW'(1);
      if (retire_fire_o) head_d = head_q + AW'(1);
      case ({alloc_fire_o, retire_fire_o})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

endmodule

// File: rtl/spec_regfile_rob.sv
// Speculative register file organised as a circular rename/reorder buffer:
// in-order allocate at tail, out-of-order result update by tag, in-order retire.
module spec_regfile_rob
  import spec_rob_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned DATA_W = ROB_DATA_W,
  parameter int unsigned PC_W   = ROB_PC_W,
  parameter int unsigned RD_W   = ROB_RD_W,
  parameter int unsigned TYPE_W = ROB_TYPE_W,
  parameter int unsigned NRD    = ROB_NRD,
  parameter int unsigned EW     = RD_W + PC_W + TYPE_W + DATA_W + 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [RD_W-1:0]   alloc_rd,
  input  logic [PC_W-1:0]   alloc_pc,
  input  logic [TYPE_W-1:0] alloc_type,
  output logic [AW-1:0]     alloc_tag,
  input  logic              upd_valid,
  input  logic [AW-1:0]     upd_tag,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [NRD*AW-1:0] rd_tag,
  output logic [NRD*EW-1:0] rd_entry,
  output logic              head_ready,
  output logic [AW-1:0]     head_tag,
  output logic [EW-1:0]     head_entry,
  input  logic              retire_en,
  input  logic              flush,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [RD_W-1:0]   rd_q    [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [TYPE_W-1:0] type_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic              svld_q  [DEPTH];
  logic              valid_q [DEPTH];

  logic          alloc_fire, retire_fire, upd_fire;
  logic [AW-1:0] head, tail;

  spec_rob_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptr (
    .clock         (clock),
    .reset         (reset),
    .flush_i       (flush),
    .alloc_req_i   (alloc_valid),
    .retire_req_i  (retire_en & head_ready),
    .alloc_fire_o  (alloc_fire),
    .retire_fire_o (retire_fire),
    .head_o        (head),
    .tail_o        (tail),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty)
  );

  assign alloc_ready = ~full;
  assign alloc_tag   = tail;
  assign head_tag    = head;
  assign head_ready  = valid_q[head] & svld_q[head];
  // Retire wins over an update to the head; tail updates fail the valid check.
  assign upd_fire    = upd_valid & valid_q[upd_tag] & ~(retire_fire && (upd_tag == head));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]    <= '0;
        pc_q[i]    <= '0;
        type_q[i]  <= '0;
        data_q[i]  <= '0;
        svld_q[i]  <= 1'b0;
        valid_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        svld_q[i]  <= 1'b0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        rd_q[tail]    <= alloc_rd;
        pc_q[tail]    <= alloc_pc;
        type_q[tail]  <= alloc_type;
        data_q[tail]  <= '0;
        svld_q[tail]  <= 1'b0;
        valid_q[tail] <= 1'b1;
      end
      if (upd_fire) begin
        data_q[upd_tag] <= upd_data;
        svld_q[upd_tag] <= 1'b1;
      end
      if (retire_fire) begin
        svld_q[head]  <= 1'b0;
        valid_q[head] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_entry   = '0;
    head_entry = {rd_q[head], pc_q[head], type_q[head], data_q[head], svld_q[head], valid_q[head]};
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_entry[k*EW +: EW] = {rd_q[rd_tag[k*AW +: AW]], pc_q[rd_tag[k*AW +: AW]],
                              type_q[rd_tag[k*AW +: AW]], data_q[rd_tag[k*AW +: AW]],
                              svld_q[rd_tag[k*AW +: AW]], valid_q[rd_tag[k*AW +: AW]]};
    end
  end

endmodule

// File: tb/tb_spec_regfile_rob.sv
// Directed self-checking bench for spec_regfile_rob.
module tb_spec_regfile_rob;
  import spec_rob_pkg::*;

  localparam int AW  = 5;
  localparam int EW  = ENTRY_W;
  localparam int NRD = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              alloc_valid, alloc_ready;
  logic [4:0]        alloc_rd;
  logic [31:0]       alloc_pc;
  logic [1:0]        alloc_type;
  logic [AW-1:0]     alloc_tag;
  logic              upd_valid;
  logic [AW-1:0]     upd_tag;
  logic [31:0]       upd_data;
  logic [NRD*AW-1:0] rd_tag;
  logic [NRD*EW-1:0] rd_entry;
  logic              head_ready;
  logic [AW-1:0]     head_tag;
  logic [EW-1:0]     head_entry;
  logic              retire_en, flush;
  logic [AW:0]       count;
  logic              full, empty;

  int checks = 0;
  int errors = 0;

  spec_regfile_rob #(
    .DEPTH (32),
    .NRD   (NRD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_rd    (alloc_rd),
    .alloc_pc    (alloc_pc),
    .alloc_type  (alloc_type),
    .alloc_tag   (alloc_tag),
    .upd_valid   (upd_valid),
    .upd_tag     (upd_tag),
    .upd_data    (upd_data),
    .rd_tag      (rd_tag),
    .rd_entry    (rd_entry),
    .head_ready  (head_ready),
    .head_tag    (head_tag),
    .head_entry  (head_entry),
    .retire_en   (retire_en),
    .flush       (flush),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic rob_entry_t port(input int k);
    return rob_entry_t'(rd_entry[k*EW +: EW]);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 128'(count), 128'd0);
    chk({tag, "_empty"}, 128'(empty), 128'd1);
    chk({tag, "_full"}, 128'(full), 128'd0);
    chk({tag, "_aready"}, 128'(alloc_ready), 128'd1);
    chk({tag, "_hready"}, 128'(head_ready), 128'd0);
    chk({tag, "_htag"}, 128'(head_tag), 128'd0);
    chk({tag, "_atag"}, 128'(alloc_tag), 128'd0);
    chk({tag, "_hentry"}, 128'(head_entry), 128'd0);
    chk({tag, "_rentry"}, 128'(rd_entry), 128'd0);
  endtask

  initial begin
    rob_entry_t e;
    reset = 1'b0; alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0; alloc_type = '0;
    upd_valid = 1'b0; upd_tag = '0; upd_data = '0; rd_tag = '0; retire_en = 1'b0; flush = 1'b0;
    #3;
    chk_reset_outputs("reset");
    #4 reset = 1'b1;
    tick();

    // Allocate three entries
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_pc = 32'h100 + 32'(4 * i); alloc_type = 2'(i);
      chk($sformatf("alloc_tag%0d", i), 128'(alloc_tag), 128'(i));
      tick();
    end
    alloc_valid = 1'b0;
    chk("count3", 128'(count), 128'd3);
    rd_tag = {5'd2, 5'd1};
    #1;
    e = port(0);
    chk("rd1_rd", 128'(e.rd), 128'd2);
    chk("rd1_pc", 128'(e.pc), 128'h104);
    chk("rd1_type", 128'(e.itype), 128'd1);
    chk("rd1_valid", 128'(e.valid), 128'd1);
    chk("rd1_svalid", 128'(e.spec_valid), 128'd0);
    e = port(1);
    chk("rd2_rd", 128'(e.rd), 128'd3);
    chk("rd2_pc", 128'(e.pc), 128'h108);

    // Out-of-order updates, in-order retire
    upd_valid = 1'b1; upd_tag = 5'd1; upd_data = 32'hDEAD;
    tick();
    chk("hready_after_t1", 128'(head_ready), 128'd0);
    upd_tag = 5'd0; upd_data = 32'hBEEF;
    chk("hready_no_bypass", 128'(head_ready), 128'd0);
    tick();
    upd_valid = 1'b0;
    chk("hready_after_t0", 128'(head_ready), 128'd1);
    e = rob_entry_t'(head_entry);
    chk("head0_data", 128'(e.spec_data), 128'hBEEF);
    retire_en = 1'b1;
    chk("head_tag0", 128'(head_tag), 128'd0);
    tick();
    chk("head_tag1", 128'(head_tag), 128'd1);
    chk("count2", 128'(count), 128'd2);
    e = rob_entry_t'(head_entry);
    chk("head1_data", 128'(e.spec_data), 128'hDEAD);
    chk("head1_rd", 128'(e.rd), 128'd2);
    tick();
    retire_en = 1'b0;
    chk("head_tag2", 128'(head_tag), 128'd2);
    chk("count1", 128'(count), 128'd1);
    chk("not_empty", 128'(empty), 128'd0);
    chk("hready_t2_pending", 128'(head_ready), 128'd0);

    // Make tag 2 ready, then fill to 32
    upd_valid = 1'b1; upd_tag = 5'd2; upd_data = 32'h2222;
    tick();
    upd_valid = 1'b0;
    for (int i = 0; i < 31; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i); alloc_pc = 32'h1000 + 32'(i);
      tick();
    end
    chk("full", 128'(full), 128'd1);
    chk("full_aready", 128'(alloc_ready), 128'd0);
    chk("count32", 128'(count), 128'd32);
    chk("full_atag", 128'(alloc_tag), 128'd2);
    retire_en = 1'b1;
    tick();
    alloc_valid = 1'b0; retire_en = 1'b0;
    chk("full_ret_count", 128'(count), 128'd31);
    chk("full_ret_head", 128'(head_tag), 128'd3);
    chk("full_ret_atag", 128'(alloc_tag), 128'd2);
    chk("full_ret_notfull", 128'(full), 128'd0);

    // Flush back to empty, then 40 single-entry round trips across the wrap
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_count", 128'(count), 128'd0);
    for (int i = 0; i < 40; i++) begin
      alloc_valid = 1'b1; alloc_pc = 32'(i); alloc_rd = 5'(i);
      chk($sformatf("wrap_atag%0d", i), 128'(alloc_tag), 128'(i % 32));
      tick();
      alloc_valid = 1'b0;
      upd_valid = 1'b1; upd_tag = 5'(i % 32); upd_data = 32'(i * 3);
      tick();
      upd_valid = 1'b0;
      chk($sformatf("wrap_htag%0d", i), 128'(head_tag), 128'(i % 32));
      chk($sformatf("wrap_hready%0d", i), 128'(head_ready), 128'd1);
      e = rob_entry_t'(head_entry);
      chk($sformatf("wrap_pc%0d", i), 128'(e.pc), 128'(i));
      chk($sformatf("wrap_data%0d", i), 128'(e.spec_data), 128'(i * 3));
      retire_en = 1'b1;
      tick();
      retire_en = 1'b0;
      chk($sformatf("wrap_count%0d", i), 128'(count), 128'd0);
    end
    chk("wrap_end_htag", 128'(head_tag), 128'd8);

    // Update to a free tag is dropped
    upd_valid = 1'b1; upd_tag = 5'd5; upd_data = 32'h5555;
    tick();
    upd_valid = 1'b0;
    rd_tag = {5'd0, 5'd5};
    #1;
    e = port(0);
    chk("free_upd_valid", 128'(e.valid), 128'd0);
    chk("free_upd_svalid", 128'(e.spec_valid), 128'd0);
    chk("free_upd_count", 128'(count), 128'd0);

    // Flush with 4 live entries and a concurrent allocate
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_pc = 32'h200 + 32'(i);
      tick();
    end
    chk("live4_count", 128'(count), 128'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_empty", 128'(empty), 128'd1);
    chk("flush_htag", 128'(head_tag), 128'd0);
    chk("flush_atag", 128'(alloc_tag), 128'd0);
    rd_tag = {5'd12, 5'd8};
    #1;
    chk("flush_e8_valid", 128'(port(0).valid), 128'd0);
    chk("flush_e12_valid", 128'(port(1).valid), 128'd0);

    // Update + retire at head in one cycle: retire wins
    alloc_valid = 1'b1; alloc_pc = 32'h300;
    tick();
    alloc_valid = 1'b0; upd_valid = 1'b1; upd_tag = 5'd0; upd_data = 32'hAAAA;
    tick();
    upd_data = 32'hBBBB; retire_en = 1'b1;
    tick();
    upd_valid = 1'b0; retire_en = 1'b0;
    rd_tag = {5'd1, 5'd0};
    #1;
    chk("updret_count", 128'(count), 128'd0);
    chk("updret_svalid", 128'(port(0).spec_valid), 128'd0);
    chk("updret_data", 128'(port(0).spec_data), 128'hAAAA);

    // Update to tail tag during its allocate cycle is dropped
    alloc_valid = 1'b1; alloc_pc = 32'h400;
    upd_valid = 1'b1; upd_tag = 5'd1; upd_data = 32'hCCCC;
    tick();
    alloc_valid = 1'b0; upd_valid = 1'b0;
    chk("tailupd_valid", 128'(port(1).valid), 128'd1);
    chk("tailupd_svalid", 128'(port(1).spec_valid), 128'd0);
    chk("tailupd_data", 128'(port(1).spec_data), 128'd0);

    // Asynchronous reset mid-operation with 10 live entries
    for (int i = 0; i < 9; i++) begin
      alloc_valid = 1'b1; alloc_pc = 32'h500 + 32'(i);
      tick();
    end
    alloc_valid = 1'b0;
    upd_valid = 1'b1; upd_tag = 5'd1; upd_data = 32'h7777;
    tick();
    chk("pre_reset_count", 128'(count), 128'd10);
    chk("pre_reset_hready", 128'(head_ready), 128'd1);
    upd_tag = 5'd2; rd_tag = {5'd2, 5'd1};
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    upd_valid = 1'b0;
    #2 reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spec_regfile_rob.md
Name: spec_regfile_rob

Overview:
Parametrised successor to the temporary speculative register file, organised as a circular rename/reorder buffer. Entries are allocated in program order at the tail and receive speculative results out of order by tag. They retire in order from the head once their result is valid. A flush clears all speculative state. The block sits between the issue/dispatch stage (allocate and read) and the commit stage (retire), with execution units writing results through the update port.

Parameters:
DEPTH, 32, number of entries; power of two, minimum 4
AW, $clog2(DEPTH), tag/pointer width
DATA_W, 32, speculative data width
PC_W, 32, PC width
RD_W, 5, architectural destination register index width
TYPE_W, 2, instruction type width
NRD, 2, number of combinational read ports

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
alloc_valid  in  1  request to allocate a new entry
alloc_ready  out  1  allocation possible this cycle (equal to !full)
alloc_rd  in  RD_W  destination register of the new entry
alloc_pc  in  PC_W  PC of the new entry
alloc_type  in  TYPE_W  instruction type of the new entry
alloc_tag  out  AW  tag that will be assigned (current tail pointer)
upd_valid  in  1  speculative result write
upd_tag  in  AW  entry being written
upd_data  in  DATA_W  speculative result
rd_tag  in  NRD*AW  read addresses, packed; port k uses bits [k*AW +: AW]
rd_entry  out  NRD*(RD_W+PC_W+TYPE_W+DATA_W+2)  packed entries; per-entry layout {rd,pc,type,spec_data,spec_valid,valid}
head_ready  out  1  head entry has valid=1 and spec_valid=1
head_tag  out  AW  head pointer
head_entry  out  RD_W+PC_W+TYPE_W+DATA_W+2  head entry contents
retire_en  in  1  pop the head; honoured only when head_ready=1
flush  in  1  discard all entries
count  out  AW+1  number of occupied entries
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (reset=0, asynchronous): all entry fields are 0, head=tail=0, count=0; full=0, empty=1, alloc_ready=1, head_ready=0.
- Allocate: when alloc_valid && !full, the entry at tail is written with {alloc_rd, alloc_pc, alloc_type, spec_data=0, spec_valid=0, valid=1}. tail increments modulo DEPTH. When alloc_valid && full, the request is ignored and no state changes.
- Update: when upd_valid and entry[upd_tag].valid==1, that entry's spec_data<=upd_data and spec_valid<=1; all other fields are unchanged. An update to an invalid entry is dropped silently. A repeated update to the same entry overwrites spec_data.
- Retire: when retire_en && head_ready, the head entry's valid and spec_valid are cleared and head increments modulo DEPTH. retire_en while !head_ready is ignored.
- count: +1 on allocate only, -1 on retire only, unchanged on both or neither. full and empty are derived from registered count.
- Simultaneous events:
  - Allocate and retire in the same cycle at full: the allocate is blocked, because full is evaluated on pre-edge state.
  - Update and retire targeting the head in the same cycle: retire takes precedence and the update is dropped.
  - An update to the current tail tag in an allocate cycle is dropped, because that entry is invalid before the edge.
- Flush (synchronous, highest priority): all valid and spec_valid bits are cleared, head=tail=0, count=0. Same-cycle allocate, update and retire are ignored. Data fields need not be cleared.
- Read ports: combinational from registered state with no write bypass. A read of an entry being updated this cycle returns the pre-edge value.
- Latency: an allocated entry becomes visible one cycle after the allocate edge; the same applies to an update. head_ready reflects an update one cycle after the update edge.
- Wrap-around: pointers roll from DEPTH-1 to 0. Ordering is preserved across the wrap.

Decomposition:
- Package spec_rob_pkg: field width localparams, field bit offsets within an entry, ENTRY_W, and a packed entry struct typedef.
- Sub-module spec_rob_ptr: head/tail/count pointer and occupancy logic, including flush. The entry array and read muxing stay in the top module.

Test Plan:
- Reset, then allocate 3 entries (rd=1,2,3; pc=0x100,0x104,0x108) -> alloc_tag 0,1,2; count=3; rd_entry of tag 1 shows rd=2, pc=0x104, valid=1, spec_valid=0.
- Update tag 1 with 0xDEAD, then tag 0 with 0xBEEF, then pulse retire_en for 2 cycles -> head_ready rises only after tag 0 is updated; entries retire in order 0 then 1; count=1; empty=0.
- Fill all 32 entries, then alloc_valid with simultaneous retire_en -> full=1, alloc_ready=0; allocate dropped; retire succeeds; count=31.
- Wrap: allocate and retire 40 entries one at a time -> alloc_tag sequence 0..31,0..7; head_tag follows the same sequence; no entry is lost.
- Update to a free tag (tag 5 with count=0), then flush with 4 entries live plus simultaneous alloc_valid -> update ignored (valid stays 0); after flush count=0, empty=1, head_tag=0, alloc_tag=0.
- Assert reset mid-operation with 10 entries live and an update in flight -> all outputs return to reset values immediately, without waiting for a clock edge.
